// File: rtl/crc16_serial_engine.sv
// Bit-serial CRC-16 engine: shifts a captured word MSB-first through an LFSR, one bit per clock.
// Optional receive-side zero-remainder flag enabled by defining CRC_CHECK_EN.
module crc16_serial_engine #(
    parameter int                 DATA_W = 40,
    parameter int                 CRC_W  = 16,
    parameter logic [CRC_W-1:0]   POLY   = 16'h1021,
    parameter logic [CRC_W-1:0]   INIT   = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic [CRC_W-1:0]  crc_out
`ifdef CRC_CHECK_EN
    ,
    output logic              crc_ok
`endif
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [CRC_W-1:0]  lfsr_q, lfsr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CRC_W-1:0]  crc_q, crc_d;
    logic              done_q, done_d;
    logic              feedback;
    logic [CRC_W-1:0]  lfsrNext;
    logic              lastShift;

    // One division step: the outgoing LFSR MSB combined with the next data bit decides the XOR.
    always_comb begin
        feedback  = lfsr_q[CRC_W-1] ^ sreg_q[DATA_W-1];
        lfsrNext  = (lfsr_q << 1) ^ (feedback ? POLY : {CRC_W{1'b0}});
        lastShift = (cnt_q == CNT_W'(DATA_W - 1));
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sreg_d  = data;
                    lfsr_d  = INIT;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sreg_d = sreg_q << 1;
                lfsr_d = lfsrNext;
                cnt_d  = cnt_q + 1'b1;
                if (lastShift) begin
                    crc_d   = lfsrNext;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            lfsr_q  <= '0;
            cnt_q   <= '0;
            crc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            done_q  <= done_d;
        end
    end

`ifdef CRC_CHECK_EN
    logic ok_q;

    // Zero remainder on a {payload,crc} word means the word arrived intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            ok_q <= 1'b0;
        end else if (state_q == SHIFT && lastShift) begin
            ok_q <= (lfsrNext == '0);
        end
    end

    assign crc_ok = ok_q;
`endif

    assign busy    = (state_q == SHIFT);
    assign done    = done_q;
    assign crc_out = crc_q;

endmodule

// File: tb/tb_crc16_serial_engine.sv
// Self-checking bench for crc16_serial_engine: directed vectors plus random words
// checked against a polynomial long-division model (crc_ok checks when CRC_CHECK_EN is defined).
module tb_crc16_serial_engine;

    logic        clk;
    logic        reset;
    logic        start;
    logic [39:0] data;
    logic        busy;
    logic        done;
    logic [15:0] crc_out;
`ifdef CRC_CHECK_EN
    logic        crc_ok;
`endif

    int errorCount = 0;
    int checkCount = 0;

    crc16_serial_engine dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data    (data),
        .busy    (busy),
        .done    (done),
        .crc_out (crc_out)
`ifdef CRC_CHECK_EN
        ,
        .crc_ok  (crc_ok)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remainder of word * x^16 divided by x^16 + POLY, done as textbook long division.
    function automatic logic [15:0] refCrc(input logic [39:0] w);
        logic [55:0] v;
        v = {w, 16'h0000};
        for (int i = 55; i >= 16; i--) begin
            if (v[i]) v = v ^ (56'h11021 << (i - 16));
        end
        return v[15:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Caller must be sitting just after a negedge; start goes high immediately so a call
    // made right after a done cycle exercises back-to-back acceptance.
    task automatic applyStimulus(input logic [39:0] word, input bit repulse,
                                 output int latency, output int busyCycles,
                                 output logic [15:0] crcSeen);
        data       = word;
        start      = 1'b1;
        latency    = 0;
        busyCycles = 0;
        while (latency < 100) begin
            @(negedge clk);
            latency++;
            start = repulse && (latency == 5 || latency == 20);
            if (repulse) data = {$urandom, $urandom};
            if (done) break;
            if (busy) busyCycles++;
        end
        crcSeen = crc_out;
    endtask

    task automatic runAndCheck(input string tag, input logic [39:0] word, input bit repulse);
        int          lat;
        int          bc;
        logic [15:0] crc;
        applyStimulus(word, repulse, lat, bc, crc);
        checkOutput({tag, "_latency"}, 64'(lat), 64'd41);
        checkOutput({tag, "_busy"}, 64'(bc), 64'd40);
        checkOutput({tag, "_crc"}, 64'(crc), 64'(refCrc(word)));
        checkOutput({tag, "_busyAtDone"}, 64'(busy), 64'd0);
`ifdef CRC_CHECK_EN
        checkOutput({tag, "_ok"}, 64'(crc_ok), 64'(refCrc(word) == 16'h0000));
`endif
    endtask

    initial begin
        int dones;
        reset = 1'b1;
        start = 1'b0;
        data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_crc", 64'(crc_out), 64'd0);
`ifdef CRC_CHECK_EN
        checkOutput("rst_ok", 64'(crc_ok), 64'd0);
`endif

        @(negedge clk);
        runAndCheck("zero", 40'h00_0000_0000, 1'b0);
        @(negedge clk);
        checkOutput("done_pulse", 64'(done), 64'd0);
        runAndCheck("one", 40'h00_0000_0001, 1'b0);
        checkOutput("one_const", 64'(crc_out), 64'h1021);
        @(negedge clk);
        checkOutput("crc_hold", 64'(crc_out), 64'h1021);
        runAndCheck("two", 40'h00_0000_0002, 1'b0);
        checkOutput("two_const", 64'(crc_out), 64'h2042);

        @(negedge clk);
        runAndCheck("check_good", {24'h000001, 16'h1021}, 1'b0);
        checkOutput("check_good_const", 64'(crc_out), 64'h0000);
        @(negedge clk);
        runAndCheck("check_bad", {24'h000001, 16'h1020}, 1'b0);

        // Re-pulsed start and changing data while busy, then a start in the done cycle.
        @(negedge clk);
        runAndCheck("repulse", 40'hA5_5A3C_C3F0, 1'b1);
        runAndCheck("b2b", 40'h12_3456_789A, 1'b0);

        // Abort a job part way through: no done must ever follow it.
        @(negedge clk);
        data  = 40'hFF_FFFF_FFFF;
        start = 1'b1;
        repeat (17) @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_crc", 64'(crc_out), 64'd0);
        dones = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("abort_nodone", 64'(dones), 64'd0);
        runAndCheck("after_abort", 40'h00_0000_0001, 1'b0);
        checkOutput("after_abort_const", 64'(crc_out), 64'h1021);

        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            runAndCheck($sformatf("rand%0d", n), {$urandom, $urandom}, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
